// File: rtl/frame_reader_pkg.sv
// Shared frame geometry, DDR command encoding and address helper for the
// framebuffer read path.
package frame_reader_pkg;

  localparam int FRAME_W       = 800;
  localparam int FRAME_H       = 600;
  localparam int ROW_STRIDE    = 1024;
  localparam int PIX_PER_BEAT  = 4;
  localparam int BEATS_PER_CMD = 2;

  localparam logic [2:0] CMD_READ = 3'b001;

  localparam logic [9:0] X_STEP = 10'(PIX_PER_BEAT * BEATS_PER_CMD);
  localparam logic [9:0] LAST_X = 10'(FRAME_W - PIX_PER_BEAT * BEATS_PER_CMD);
  localparam logic [9:0] LAST_Y = 10'(FRAME_H - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Stride is a power of two, so this reduces to base + {y, x}.
  function automatic logic [30:0] cmd_addr(input logic [30:0] base,
                                           input logic [9:0]  y,
                                           input logic [9:0]  x);
    return base + 31'(y) * 31'(ROW_STRIDE) + 31'(x);
  endfunction

endpackage

// File: rtl/frame_reader_if.sv
// DDR address/read-data FIFO ports and the outgoing video stream of the
// framebuffer reader; master is the reader, slave is its environment.
interface frame_reader_if;
  logic         af_full;
  logic [30:0]  af_addr_din;
  logic [2:0]   af_cmd_din;
  logic         af_wr_en;
  logic         rdf_valid;
  logic [127:0] rdf_dout;
  logic [23:0]  video;
  logic         video_valid;
  logic         video_ready;
  logic         overflow;

  modport master (
    input  af_full, rdf_valid, rdf_dout, video_ready,
    output af_addr_din, af_cmd_din, af_wr_en, video, video_valid, overflow
  );

  modport slave (
    output af_full, rdf_valid, rdf_dout, video_ready,
    input  af_addr_din, af_cmd_din, af_wr_en, video, video_valid, overflow
  );
endinterface

// File: rtl/frame_reader_word_fifo.sv
// Generic single-clock word FIFO with occupancy-derived full/empty flags.
// Latency: a word written in cycle N is visible on dout/!empty in cycle N+1.
// Backpressure: writes while full and reads while empty are ignored.
module word_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_wr;
  logic             do_rd;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      if (do_wr && !do_rd)      count <= count + (AW+1)'(1);
      else if (do_rd && !do_wr) count <= count - (AW+1)'(1);
    end
  end

  // Storage needs no reset; consumers qualify dout with !empty.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/frame_reader.sv
// Framebuffer read engine: walks the frame issuing DDR reads, unpacks beats to pixels.
// Latency: beat accepted in cycle N gives its first pixel in cycle N+1; af_wr_en is combinational.
// Backpressure: credits bound outstanding reads to buffer space, so rdf is never stalled.
module frame_reader
  import frame_reader_pkg::*;
#(
  parameter logic [30:0] FB_BASE     = 31'h0010_0000,
  parameter int          DEPTH_WORDS = 16
) (
  input  logic           clk,
  input  logic           rst,
  frame_reader_if.master bus
);

  localparam int CW = $clog2(DEPTH_WORDS) + 1;

  state_t         state;
  state_t         state_nxt;
  logic [9:0]     req_x;
  logic [9:0]     req_y;
  logic [CW-1:0]  credits;
  logic [1:0]     idx;
  logic [127:0]   word;
  logic           fifo_full;
  logic           fifo_empty;
  logic           issue;
  logic           pop;
  logic           pop_last;
  logic           overflow_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    case (state)
      IDLE:    state_nxt = RUN;
      RUN:     issue = (credits >= CW'(BEATS_PER_CMD)) && !bus.af_full;
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.af_wr_en    = issue;
  assign bus.af_cmd_din  = CMD_READ;
  assign bus.af_addr_din = cmd_addr(FB_BASE, req_y, req_x);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_x <= '0;
      req_y <= '0;
    end else if (issue) begin
      if (req_x == LAST_X) begin
        req_x <= '0;
        req_y <= (req_y == LAST_Y) ? 10'd0 : req_y + 10'd1;
      end else begin
        req_x <= req_x + X_STEP;
      end
    end
  end

  // Issue reserves a command's worth of words; retiring a word frees one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) credits <= CW'(DEPTH_WORDS);
    else     credits <= credits - (issue ? CW'(BEATS_PER_CMD) : '0)
                                + (pop_last ? CW'(1) : '0);
  end

  word_fifo #(
    .WIDTH (128),
    .DEPTH (DEPTH_WORDS)
  ) u_buf (
    .clk   (clk),
    .rst   (rst),
    .wr_en (bus.rdf_valid),
    .din   (bus.rdf_dout),
    .rd_en (pop_last),
    .dout  (word),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bus.video_valid = !fifo_empty;
  assign pop      = bus.video_valid && bus.video_ready;
  assign pop_last = pop && (idx == 2'd3);
  assign bus.video = fifo_empty ? 24'd0 : word[{idx, 5'd0} +: 24];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx        <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (pop) idx <= idx + 2'd1;
      if (bus.rdf_valid && fifo_full) overflow_q <= 1'b1;
    end
  end

  assign bus.overflow = overflow_q;

endmodule

// File: doc/frame_reader.md
# frame_reader

Framebuffer read engine: walks an 800x600 frame of 32-bit pixels in DDR row-major, issues read commands on the memory address FIFO and unpacks returned 128-bit read-data beats into a one-pixel-per-cycle video stream. It sits between the DDR2 read path (af/rdf) and the display timing controller. It is the read-side counterpart of the pixel write path used by the drawing engines. A credit counter guarantees every outstanding read has buffer space, so rdf is never back-pressured.

## Interface
- FB_BASE, 31'h0010_0000, framebuffer base address in 32-bit-word units
- DEPTH_WORDS, 16, local buffer depth in 128-bit words; power of two, at least 4
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- af_full  in  1  address FIFO full
- af_addr_din  out  31  read address
- af_cmd_din  out  3  command; always 3'b001 (read)
- af_wr_en  out  1  push address/command
- rdf_valid  in  1  read-data beat valid; no back-pressure
- rdf_dout  in  128  read-data beat
- video  out  24  pixel RGB, pixel[23:0]
- video_valid  out  1  pixel available
- video_ready  in  1  consumer accepts pixel
- overflow  out  1  sticky: rdf beat arrived with buffer full

## Operation
- Read command: af_addr_din = FB_BASE + {req_y[9:0], req_x[9:0]}, so the row stride is 1024 words. req_x is always a multiple of 8.
- Each command returns exactly 2 rdf beats (8 pixels). The first beat carries pixels x..x+3; within a beat, pixel k is in bits [32k+31:32k].
- Request walk: req_x steps by 8 over 0..792. On issuing at req_x=792: req_x←0, req_y←req_y+1. On issuing at req_y=599, req_x=792: wrap to (0,0), which is the next frame.
- Credits: credits counts free buffer words minus words owed to outstanding reads. Reset value DEPTH_WORDS; width clog2(DEPTH_WORDS)+1.
  - Issue condition: credits≥2 and !af_full. On issue, credits −2.
  - When the last pixel (k=3) of a buffered word is popped, credits +1.
  - If both happen in the same cycle, the net change is −1.
- Buffer: FIFO of 128-bit words, written on rdf_valid. The output holds a 2-bit pixel index; a pop (video_valid & video_ready) advances the index, and index 3→0 dequeues the word.
- video_valid = buffer non-empty; video = current word[32·idx+23 : 32·idx].
- Buffer overflow cannot occur by construction. If rdf_valid arrives while the buffer is full, drop the beat and set overflow, which is held until reset.
- States: IDLE (reset only) → RUN one cycle after reset deassertion. RUN is the steady state. No other states.

## Timing
- Reset values:
  - af_wr_en=0, af_cmd_din=3'b001, af_addr_din=FB_BASE
  - video_valid=0, video=0, overflow=0
  - req_x=req_y=0, idx=0, buffer empty, credits=DEPTH_WORDS
- af_wr_en is combinational from registered state: asserted in the first RUN cycle if the issue condition holds. A command can issue every cycle while credits permit.
- Read latency from DDR is unbounded. Correctness depends only on in-order rdf return.
- An rdf beat written in cycle N sets video_valid in cycle N+1 (registered FIFO, no fall-through).
- Throughput: one pixel per cycle when video_ready is held high, and reads keep up.
- Reset mid-frame: state clears immediately. Beats still in flight after reset count as owed to a flushed request and are written normally. The memory controller is reset together with this block, so none arrive.

## Structure
- Shared package constants:
  - FRAME_W=800, FRAME_H=600, ROW_STRIDE=1024
  - PIX_PER_BEAT=4, BEATS_PER_CMD=2
  - CMD_READ=3'b001
- Sub-module: word_fifo (synchronous, parameterised width/depth, full/empty flags, registered output). It is reusable by other DDR clients.
- Top level holds the request counters, credit counter, pixel index mux and overflow flag.

## Test plan
- Reset then af_full=0, no rdf responses: exactly 8 commands issue (16 credits / 2) at addresses 0x100000, 0x100008, …, 0x100038. af_wr_en then stays 0.
- Return 2 beats with pixels 0x00AABBCC+k (k=0..7), video_ready=1: video shows AABBCC..AABBD3 on 8 consecutive cycles, and exactly 1 new command issues.
- Hold af_full=1 for 10 cycles: no af_wr_en. Release: issuing resumes at the same address.
- Run a full frame with a model DDR: after the command at req_y=599, req_x=792 (address FB_BASE+0x95F18), the next command is FB_BASE+0. The video pixel count per frame is 480000.
- Toggle video_ready randomly at 50%: no pixel lost or duplicated, and credits never go negative. Force an extra rdf beat while full: overflow=1 and stays 1.
- Assert rst mid-frame with data buffered: the next cycle shows video_valid=0 and af_addr_din=FB_BASE, and the walk restarts at (0,0).
